cpu_run_controller: RTL and testbench
=====================================

# cpu_run_controller

Sequencer that owns the CPU top's external memory ports and run control. After a `start` pulse it streams a program into instruction memory and an initial image into data memory. It then releases the CPU from reset and asserts `cpu_enable` for a programmed cycle budget. Finally it reads back a programmed number of data-memory words over a valid/ready output stream. It sits between the test/host interface and the CPU top, replacing direct host drive of the `*_ext` and `*_ext_2` ports.

## Interface
- IMEM_DEPTH, 128: instruction-memory capacity in 32-bit words
- DMEM_DEPTH, 128: data-memory capacity in 64-bit words
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load/run/dump sequence; ignored unless in IDLE or DONE
- run_cycles  in  32  cycle budget, sampled on accepted start
- dump_count  in  16  data words to read back, sampled on accepted start
- load_valid / load_ready  in / out  1  load stream handshake
- load_data  in  64  load word; bits [31:0] only during the imem phase
- load_last  in  1  marks the final word of the current segment (imem, then dmem)
- dump_valid / dump_ready  out / in  1  readback stream handshake
- dump_data  out  64  readback word
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- error  out  1  segment overflow flag, valid while done=1
- cpu_rst_n  out  1  CPU reset (active low)
- cpu_enable  out  1  CPU enable
- addr_ext  out  64  imem byte address
- wen_ext  out  1  imem write enable
- ren_ext  out  1  imem read enable
- wdata_ext  out  32  imem write data
- addr_ext_2  out  64  dmem byte address
- wen_ext_2  out  1  dmem write enable
- ren_ext_2  out  1  dmem read enable
- wdata_ext_2  out  64  dmem write data
- rdata_ext_2  in  64  dmem read data

## Operation
- **States:** IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE.
- **Reset (any state, mid-operation included):** state goes to IDLE, all counters clear. Every output is 0, except `cpu_rst_n`, which is also 0.
- **Start:** IDLE or DONE with start=1 goes to LOAD_I. This captures `run_cycles` and `dump_count`, clears word counters and clears error.
- **LOAD_I:**
  - `load_ready`=1.
  - Word k accepted on `load_valid & load_ready` produces, on the next cycle: `wen_ext`=1, `addr_ext`=4k, `wdata_ext`=`load_data[31:0]`.
  - Accepted word with `load_last` goes to LOAD_D.
  - Accepting word IMEM_DEPTH-1 without `load_last` sets error and goes to DONE; that word is still written.
- **LOAD_D:** same rules as LOAD_I, on the `_2` ports, with `addr_ext_2`=8k and full 64-bit data. Overflow limit is DMEM_DEPTH. Accepted `load_last` goes to RUN.
- **RUN:**
  - `cpu_rst_n`=1 from RUN entry onward; it stays 1 until reset or the next start.
  - `cpu_enable`=1 for exactly `run_cycles` consecutive cycles, beginning the cycle after RUN entry. It then drops and the state goes to DUMP_RD.
  - `run_cycles`=0 gives no enable cycles and RUN lasts one cycle.
- **Dump loop:**
  - DUMP_RD: `ren_ext_2`=1, `addr_ext_2`=8j.
  - DUMP_WAIT: capture `rdata_ext_2` (1-cycle registered read latency) into the output register.
  - DUMP_OUT: `dump_valid`=1, `dump_data` held stable until `dump_ready`.
  - On handshake j increments. The state returns to DUMP_RD if j < `dump_count`, else goes to DONE.
  - `dump_count`=0 goes from RUN directly to DONE.
  - `dump_count` > DMEM_DEPTH is clamped to DMEM_DEPTH.
- **Port exclusivity:** `*_ext` and `*_ext_2` enables are 0 whenever the state is not LOAD_I, LOAD_D or DUMP_RD. `ren_ext` is always 0.
- **DONE:** `done`=1 and `cpu_rst_n` holds its value; stays in DONE until start or reset.

## Timing
- All outputs are registered; no combinational input-to-output paths except `load_ready`, which is a function of state only.
- Load throughput: one word per cycle. The memory write lands 1 cycle after acceptance. The final segment write completes in the cycle the state enters the next phase.
- Dump throughput: one word per 3 cycles with `dump_ready` held high.
- start asserted while busy: no effect.
- load_valid outside LOAD_I/LOAD_D: ignored (`load_ready`=0).
- Counters: word counters are IMEM/DMEM address-width+1 bits. The run counter is 32 bits and counts down to 0 with no wrap.

## Test plan
- **Nominal sequence.** Reset, then start with run_cycles=10 and dump_count=2. Load 3 imem words (last on the 3rd) and 2 dmem words.
  - Required: `wen_ext` at addr 0,4,8, then `wen_ext_2` at 0,8.
  - `cpu_enable` high exactly 10 cycles.
  - `dump_data` returns the two dmem words; then done=1, error=0.
- **Imem overflow.** IMEM_DEPTH=4, 4 imem words with no `load_last`. Required: 4 writes (addr 0..12), then done=1 and error=1; `cpu_enable` never asserted.
- **Zero budget and zero dump.** run_cycles=0, dump_count=0. Required: `cpu_enable` never 1, `cpu_rst_n` rises, done within 2 cycles after the dmem last-word write.
- **Dump backpressure.** `dump_ready` held low 5 cycles. Required: `dump_valid` stays 1, `dump_data` stays constant, no new `ren_ext_2` issued until the handshake.
- **Reset mid-RUN.** Assert rst at enable cycle 3 of 10. Required: next cycle all outputs 0 (`cpu_rst_n`=0); a later start begins a fresh LOAD_I at addr 0.
- **Start while busy.** Pulse start during LOAD_D. Required: ignored, sequence continues unchanged.

Source files
------------

// File: rtl/cpu_run_controller_if.sv
// Load and dump streams between the host side and the CPU run controller.
// The controller sits on the slave modport; the host/test side uses master.
interface cpu_run_controller_if;
  logic        load_valid;
  logic        load_ready;
  logic [63:0] load_data;
  logic        load_last;
  logic        dump_valid;
  logic        dump_ready;
  logic [63:0] dump_data;

  modport master (
    output load_valid, load_data, load_last, dump_ready,
    input  load_ready, dump_valid, dump_data
  );

  modport slave (
    input  load_valid, load_data, load_last, dump_ready,
    output load_ready, dump_valid, dump_data
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Load/run/dump sequencer owning the CPU top's external memory ports and run control.
// Streams imem then dmem images in, runs the CPU for a fixed budget, then reads dmem back.
module cpu_run_controller #(
  parameter int unsigned IMEM_DEPTH = 128,
  parameter int unsigned DMEM_DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [31:0]                run_cycles,
  input  logic [15:0]                dump_count,
  cpu_run_controller_if.slave        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       cpu_rst_n,
  output logic                       cpu_enable,
  output logic [63:0]                addr_ext,
  output logic                       wen_ext,
  output logic                       ren_ext,
  output logic [31:0]                wdata_ext,
  output logic [63:0]                addr_ext_2,
  output logic                       wen_ext_2,
  output logic                       ren_ext_2,
  output logic [63:0]                wdata_ext_2,
  input  logic [63:0]                rdata_ext_2
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH) + 1;
  localparam int unsigned DAW = $clog2(DMEM_DEPTH) + 1;

  typedef enum logic [2:0] {
    StIdle, StLoadI, StLoadD, StRun, StDumpRd, StDumpWait, StDumpOut, StDone
  } state_e;

  state_e           state_q;
  logic [IAW-1:0]   i_cnt_q;
  logic [DAW-1:0]   d_cnt_q;
  logic [31:0]      run_cnt_q;
  logic [15:0]      dump_n_q;
  logic             dump_valid_q;
  logic [63:0]      dump_data_q;

  logic [IAW-1:0]   i_nxt;
  logic [DAW-1:0]   d_nxt;
  logic [15:0]      dump_clamp;
  logic             more_dump;

  assign i_nxt      = i_cnt_q + IAW'(1);
  assign d_nxt      = d_cnt_q + DAW'(1);
  assign dump_clamp = (32'(dump_count) > DMEM_DEPTH) ? 16'(DMEM_DEPTH) : dump_count;
  assign more_dump  = 16'(d_nxt) < dump_n_q;

  // Only unregistered output: ready depends on state alone.
  assign bus.load_ready = (state_q == StLoadI) || (state_q == StLoadD);
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_data  = dump_data_q;
  assign ren_ext        = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
      run_cnt_q    <= '0;
      dump_n_q     <= '0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_rst_n    <= 1'b0;
      cpu_enable   <= 1'b0;
      addr_ext     <= '0;
      wen_ext      <= 1'b0;
      wdata_ext    <= '0;
      addr_ext_2   <= '0;
      wen_ext_2    <= 1'b0;
      ren_ext_2    <= 1'b0;
      wdata_ext_2  <= '0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StLoadI;
            run_cnt_q  <= run_cycles;
            dump_n_q   <= dump_clamp;
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
            error      <= 1'b0;
            cpu_rst_n  <= 1'b0;
            cpu_enable <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        StLoadI: begin
          if (bus.load_valid) begin
            wen_ext   <= 1'b1;
            addr_ext  <= 64'(i_cnt_q) << 2;
            wdata_ext <= bus.load_data[31:0];
            i_cnt_q   <= i_nxt;
            if (bus.load_last) begin
              state_q <= StLoadD;
            end else if (i_cnt_q == IAW'(IMEM_DEPTH - 1)) begin
              error   <= 1'b1;
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        StLoadD: begin
          if (bus.load_valid) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= 64'(d_cnt_q) << 3;
            wdata_ext_2 <= bus.load_data;
            if (bus.load_last) begin
              // Word counter is reused as the dump index from here on.
              d_cnt_q   <= '0;
              state_q   <= StRun;
              cpu_rst_n <= 1'b1;
            end else begin
              d_cnt_q <= d_nxt;
              if (d_cnt_q == DAW'(DMEM_DEPTH - 1)) begin
                error   <= 1'b1;
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
        end
        StRun: begin
          if (run_cnt_q != '0) begin
            cpu_enable <= 1'b1;
            run_cnt_q  <= run_cnt_q - 32'd1;
          end else begin
            cpu_enable <= 1'b0;
            if (dump_n_q == '0) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q    <= StDumpRd;
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= '0;
            end
          end
        end
        StDumpRd: begin
          state_q <= StDumpWait;
        end
        StDumpWait: begin
          dump_data_q  <= rdata_ext_2;
          dump_valid_q <= 1'b1;
          state_q      <= StDumpOut;
        end
        StDumpOut: begin
          if (bus.dump_ready) begin
            dump_valid_q <= 1'b0;
            d_cnt_q      <= d_nxt;
            if (more_dump) begin
              state_q    <= StDumpRd;
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= 64'(d_nxt) << 3;
            end else begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a behavioural dmem model and write/enable monitors.
module tb_cpu_run_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] run_cycles;
  logic [15:0] dump_count;
  logic        busy, done, error, cpu_rst_n, cpu_enable;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;

  int checks   = 0;
  int failures = 0;

  cpu_run_controller_if bus ();

  cpu_run_controller #(.IMEM_DEPTH(4), .DMEM_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .run_cycles  (run_cycles),
    .dump_count  (dump_count),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2)
  );

  always #5 clk = ~clk;

  // Data memory with one-cycle registered read.
  logic [63:0] dmem [8];
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[5:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[5:3]];
  end

  logic [63:0] iw_addr [$];
  logic [31:0] iw_data [$];
  logic [63:0] dw_addr [$];
  logic [63:0] dump_q  [$];
  int          en_cnt;
  int          ren_cnt;

  always @(negedge clk) begin
    if (wen_ext === 1'b1) begin
      iw_addr.push_back(addr_ext);
      iw_data.push_back(wdata_ext);
    end
    if (wen_ext_2 === 1'b1) dw_addr.push_back(addr_ext_2);
    if (cpu_enable === 1'b1) en_cnt++;
    if (ren_ext_2 === 1'b1) ren_cnt++;
    if (bus.dump_valid === 1'b1 && bus.dump_ready === 1'b1) dump_q.push_back(bus.dump_data);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    iw_addr.delete();
    iw_data.delete();
    dw_addr.delete();
    dump_q.delete();
    en_cnt  = 0;
    ren_cnt = 0;
  endtask

  task automatic do_start(input logic [31:0] rc, input logic [15:0] dc);
    run_cycles = rc;
    dump_count = dc;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] data, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;

  initial begin
    int n;
    rst            = 1'b1;
    start          = 1'b0;
    run_cycles     = '0;
    dump_count     = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.dump_ready = 1'b0;
    clear_mon();
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_dump_valid", bus.dump_valid, 0);
    rst = 1'b0;
    tick();

    // Nominal sequence with start pulsed mid-LOAD_D and dump backpressure.
    clear_mon();
    do_start(32'd10, 16'd2);
    check("nom_busy", busy, 1);
    check("nom_load_ready", bus.load_ready, 1);
    send_word(64'hAAAA_0000_1111_0001, 1'b0);
    send_word(64'hAAAA_0000_2222_0002, 1'b0);
    send_word(64'hAAAA_0000_3333_0003, 1'b1);
    start = 1'b1;
    send_word(D0, 1'b0);
    start = 1'b0;
    check("busy_start_ignored", busy, 1);
    send_word(D1, 1'b1);
    check("run_cpu_rst_n", cpu_rst_n, 1);
    n = 0;
    while (bus.dump_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("dump_valid_seen", bus.dump_valid, 1);
    check("nom_en_cnt", 64'(en_cnt), 10);
    check("first_ren", 64'(ren_cnt), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", bus.dump_valid, 1);
      check("bp_data", bus.dump_data, D0);
    end
    check("bp_no_ren", 64'(ren_cnt), 1);
    bus.dump_ready = 1'b1;
    wait_done(50, "nom_done");
    check("nom_error", error, 0);
    check("nom_busy_end", busy, 0);
    check("nom_iw_n", 64'(iw_addr.size()), 3);
    if (iw_addr.size() == 3) begin
      check("iw_a0", iw_addr[0], 0);
      check("iw_a1", iw_addr[1], 4);
      check("iw_a2", iw_addr[2], 8);
      check("iw_d2", 64'(iw_data[2]), 64'h3333_0003);
    end
    check("nom_dw_n", 64'(dw_addr.size()), 2);
    if (dw_addr.size() == 2) begin
      check("dw_a0", dw_addr[0], 0);
      check("dw_a1", dw_addr[1], 8);
    end
    check("dump_n", 64'(dump_q.size()), 2);
    if (dump_q.size() == 2) begin
      check("dump_w0", dump_q[0], D0);
      check("dump_w1", dump_q[1], D1);
    end
    check("nom_ren_total", 64'(ren_cnt), 2);

    // Imem overflow with IMEM_DEPTH=4.
    clear_mon();
    bus.dump_ready = 1'b0;
    do_start(32'd5, 16'd1);
    for (int i = 0; i < 4; i++) send_word(64'(i + 16), 1'b0);
    check("ovf_done", done, 1);
    check("ovf_error", error, 1);
    tick();
    check("ovf_iw_n", 64'(iw_addr.size()), 4);
    if (iw_addr.size() == 4) check("ovf_last_addr", iw_addr[3], 12);
    check("ovf_no_enable", 64'(en_cnt), 0);
    check("ovf_cpu_rst_n", cpu_rst_n, 0);
    check("ovf_load_ready", bus.load_ready, 0);

    // Zero run budget and zero dump count, started from DONE.
    clear_mon();
    do_start(32'd0, 16'd0);
    check("zero_error_cleared", error, 0);
    send_word(64'h55, 1'b1);
    send_word(64'h66, 1'b1);
    check("zero_wen2", wen_ext_2, 1);
    check("zero_cpu_rst_n", cpu_rst_n, 1);
    tick();
    check("zero_done", done, 1);
    check("zero_no_enable", 64'(en_cnt), 0);

    // Reset asserted during the third enable cycle of ten.
    clear_mon();
    do_start(32'd10, 16'd1);
    send_word(64'h77, 1'b1);
    send_word(64'h88, 1'b1);
    tick();
    tick();
    tick();
    check("mid_enable", cpu_enable, 1);
    rst = 1'b1;
    tick();
    check("mr_cpu_enable", cpu_enable, 0);
    check("mr_cpu_rst_n", cpu_rst_n, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_load_ready", bus.load_ready, 0);
    rst = 1'b0;
    tick();
    do_start(32'd3, 16'd1);
    send_word(64'h99, 1'b0);
    check("mr_wen", wen_ext, 1);
    check("mr_addr0", addr_ext, 0);
    check("mr_wdata", 64'(wdata_ext), 64'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
